subckt_sig_sequencer: RTL and testbench

//  Sequences one extracted netlist subcircuit (DUT) through a signature test for trojan detection.
//  It holds the DUT in reset, then drives LFSR pseudo-random stimulus into the DUT data inputs.
//  It compacts the DUT response into a 16-bit MISR and compares the result against a golden signature.
//  It sits between the bench/host control and one subcircuit instance; the DUT shares clock I1470 and reset I1477.

---
 rtl/subckt_sig_sequencer.sv | 135 +++++++++++++
 tb/tb_subckt_sig_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/subckt_sig_sequencer.sv
// Signature-test sequencer for one extracted subcircuit: holds it in reset, drives LFSR
// stimulus, compacts its response into a 16-bit MISR and compares against a golden value.
module subckt_sig_sequencer #(
  parameter int STIM_W  = 4,
  parameter int RESP_W  = 1,
  parameter int CNT_W   = 16,
  parameter int LAT     = 3,
  parameter int RST_CYC = 2
) (
  input  logic              I1470,
  input  logic              I1477,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       seed,
  input  logic [CNT_W-1:0]  n_vectors,
  input  logic [15:0]       golden_sig,
  input  logic [RESP_W-1:0] resp_i,
  output logic [STIM_W-1:0] stim_o,
  output logic              dut_rst_o,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature
);

  // One spare bit so n_vectors + LAT never wraps the phase counter.
  localparam int K_W = CNT_W + 1;
  localparam logic [K_W-1:0] RST_LAST = K_W'(RST_CYC - 1);
  localparam logic [K_W-1:0] LAT_K    = K_W'(LAT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    APPLY = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [K_W-1:0]   cnt, cnt_nxt;
  logic [K_W-1:0]   apply_last, flush_last;
  logic [CNT_W-1:0] n_lat;
  logic [15:0]      lfsr, misr;
  logic             accept, capture;

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign apply_last = {1'b0, n_lat} - K_W'(1);
  assign flush_last = {1'b0, n_lat} + LAT_K - K_W'(1);

  assign busy      = (state == RST) || (state == APPLY) || (state == FLUSH);
  assign dut_rst_o = !((state == APPLY) || (state == FLUSH));
  assign stim_o    = (state == APPLY) ? lfsr[STIM_W-1:0] : '0;
  assign done      = (state == DONE) && !abort;
  // cnt runs continuously from the first APPLY cycle, so it is the response index k.
  assign capture   = ((state == APPLY) || (state == FLUSH)) && (cnt >= LAT_K);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RST;
        end
      end
      RST: begin
        if (cnt == RST_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (n_lat == '0) ? DONE : APPLY;
        end else begin
          cnt_nxt = cnt + K_W'(1);
        end
      end
      APPLY: begin
        cnt_nxt = cnt + K_W'(1);
        if (cnt == apply_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        cnt_nxt = cnt + K_W'(1);
        if (cnt == flush_last) state_nxt = DONE;
      end
      DONE: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    // abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      accept    = 1'b0;
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      state     <= IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      lfsr      <= '0;
      misr      <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        n_lat <= n_vectors;
        lfsr  <= (seed == 16'h0000) ? 16'hACE1 : seed;
        misr  <= '0;
        pass  <= 1'b0;
      end else begin
        if (state == APPLY) lfsr <= shift16(lfsr);
        if (capture)        misr <= shift16(misr) ^ 16'(resp_i);
      end
      if (abort) begin
        pass <= 1'b0;
      end else if (state == DONE) begin
        pass      <= (misr == golden_sig);
        signature <= misr;
      end
    end
  end

endmodule

// File: tb/tb_subckt_sig_sequencer.sv
// Bench for subckt_sig_sequencer: a timeline model derived from run start checks every
// output each cycle, and directed runs pin hand-computed results.
module tb_subckt_sig_sequencer;
  localparam int STIM_W  = 4;
  localparam int RESP_W  = 1;
  localparam int CNT_W   = 16;
  localparam int LAT     = 3;
  localparam int RST_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic I1477;
  always #5 clk = ~clk;

  logic              start, abort;
  logic [15:0]       seed, golden_sig;
  logic [CNT_W-1:0]  n_vectors;
  logic [RESP_W-1:0] resp_i;
  logic [STIM_W-1:0] stim_o;
  logic              dut_rst_o, busy, done, pass;
  logic [15:0]       signature;

  subckt_sig_sequencer #(
    .STIM_W(STIM_W), .RESP_W(RESP_W), .CNT_W(CNT_W), .LAT(LAT), .RST_CYC(RST_CYC)
  ) dut (
    .I1470(clk), .I1477(I1477), .start(start), .abort(abort), .seed(seed),
    .n_vectors(n_vectors), .golden_sig(golden_sig), .resp_i(resp_i),
    .stim_o(stim_o), .dut_rst_o(dut_rst_o), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] shift16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // ---------------- response source ----------------
  // mode 0: random, 1: constant 1, 2: parity of stimulus seen LAT cycles earlier
  int resp_mode = 1;
  logic [STIM_W-1:0] hist [LAT];

  always @(negedge clk) begin
    for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = stim_o;
  end

  always @(posedge clk) begin
    #1;
    case (resp_mode)
      0:       resp_i = RESP_W'($urandom_range(0, 1));
      1:       resp_i = RESP_W'(1);
      default: resp_i = RESP_W'(^hist[LAT-1]);
    endcase
  end

  // ---------------- reference model ----------------
  // Tracks t = cycles since the accepted start and derives every output from the run timeline.
  bit          act_m;
  int          t_m, n_m, t_done, k_m;
  bit          in_apply, in_flush;
  logic [15:0] lfsr_m, misr_m, sig_m;
  logic        pass_m;

  always @(negedge clk) begin
    if (I1477) begin
      act_m  = 0;
      pass_m = 1'b0;
      sig_m  = 16'h0000;
    end else begin
      t_done   = (n_m == 0) ? RST_CYC + 1 : RST_CYC + n_m + LAT + 1;
      in_apply = act_m && n_m > 0 && t_m >= RST_CYC + 1 && t_m <= RST_CYC + n_m;
      in_flush = act_m && n_m > 0 && t_m > RST_CYC + n_m && t_m <= RST_CYC + n_m + LAT;
      check("m_busy", busy, act_m && t_m < t_done);
      check("m_dut_rst", dut_rst_o, !(in_apply || in_flush));
      check("m_stim", stim_o, in_apply ? lfsr_m[STIM_W-1:0] : '0);
      check("m_done", done, act_m && t_m == t_done && !abort);
      check("m_pass", pass, pass_m);
      check("m_signature", signature, sig_m);
      if (abort) begin
        act_m  = 0;
        pass_m = 1'b0;
      end else if (act_m) begin
        if (in_apply) lfsr_m = shift16(lfsr_m);
        k_m = t_m - RST_CYC - 1;
        if (n_m > 0 && k_m >= LAT && k_m < n_m + LAT)
          misr_m = shift16(misr_m) ^ 16'(resp_i);
        if (t_m == t_done) begin
          sig_m  = misr_m;
          pass_m = (misr_m == golden_sig);
          act_m  = 0;
        end else begin
          t_m++;
        end
      end else if (start) begin
        act_m  = 1;
        t_m    = 1;
        n_m    = int'(n_vectors);
        lfsr_m = (seed == 16'h0000) ? 16'hACE1 : seed;
        misr_m = 16'h0000;
        pass_m = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [STIM_W-1:0] stim_q[$];
  logic [STIM_W-1:0] exp_q[$];
  int low_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and watches it for up to max_c cycles; done_c = cycle of done, or -1.
  task automatic run(input logic [15:0] s, input int n, input logic [15:0] g,
                     input int pulse_c, input int abort_c, input int max_c, output int done_c);
    seed = s; n_vectors = CNT_W'(n); golden_sig = g; start = 1'b1;
    step();
    start = 1'b0;
    done_c = -1; low_cnt = 0; stim_q.delete();
    for (int c = 1; c <= max_c; c++) begin
      start = (c == pulse_c);
      abort = (c == abort_c);
      if (start) begin seed = 16'h7777; n_vectors = CNT_W'(9); end
      @(negedge clk);
      if (!dut_rst_o) begin low_cnt++; stim_q.push_back(stim_o); end
      if (done) done_c = c;
      step();
      start = 1'b0;
      abort = 1'b0;
      if (done_c >= 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed tests ----------------
  int dc;
  logic [15:0] gold;

  initial begin
    for (int i = 0; i < LAT; i++) hist[i] = '0;
    I1477 = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; n_vectors = '0;
    golden_sig = '0; resp_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", stim_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, 0);
    check("rst_dut_rst", dut_rst_o, 1);
    I1477 = 1'b0;
    step();

    // seed 1, five vectors, constant-1 response: MISR 1,3,7,F,1F
    resp_mode = 1;
    exp_q = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    run(16'h0001, 5, 16'h001F, -1, -1, 100, dc);
    check("t1_done_cycle", dc, 1 + RST_CYC + 5 + LAT);
    check("t1_low_cycles", low_cnt, 5 + LAT);
    for (int i = 0; i < 5; i++) check("t1_stim_seq", stim_q[i], exp_q[i]);
    check("t1_sig", signature, 16'h001F);
    check("t1_pass", pass, 1);

    // abort in APPLY cycle 3 keeps the previous signature
    run(16'h0001, 5, 16'h001F, -1, RST_CYC + 4, 20, dc);
    check("t4_no_done", dc, -1);
    check("t4_busy", busy, 0);
    check("t4_sig_kept", signature, 16'h001F);
    check("t4_pass", pass, 0);

    // zero vectors
    run(16'h0001, 0, 16'h0000, -1, -1, 50, dc);
    check("t2_done_cycle", dc, 1 + RST_CYC);
    check("t2_low_cycles", low_cnt, 0);
    check("t2_sig", signature, 16'h0000);
    check("t2_pass", pass, 1);

    // zero seed uses ACE1
    run(16'h0000, 2, 16'h0003, -1, -1, 50, dc);
    check("t7_first_stim", stim_q[0], 4'h1);
    check("t7_sig", signature, 16'h0003);
    check("t7_pass", pass, 1);

    // start while busy is ignored; then start+abort in IDLE
    run(16'h0005, 4, 16'h000F, 4, -1, 50, dc);
    check("t5_done_cycle", dc, 1 + RST_CYC + 4 + LAT);
    check("t5_sig", signature, 16'h000F);
    check("t5_pass", pass, 1);
    start = 1'b1; abort = 1'b1; seed = 16'h0042; n_vectors = CNT_W'(3);
    step();
    start = 1'b0; abort = 1'b0;
    check("t5_sa_busy", busy, 0);
    repeat (4) step();
    check("t5_sa_idle", busy, 0);

    // long run with a response that depends on the stimulus
    resp_mode = 2;
    run(16'h1234, 1000, 16'h0000, -1, -1, 1100, dc);
    check("t3_done_cycle", dc, 1 + RST_CYC + 1000 + LAT);
    gold = sig_m;
    run(16'h1234, 1000, gold, -1, -1, 1100, dc);
    check("t3_pass_gold", pass, 1);
    run(16'h1234, 1000, gold ^ 16'h0100, -1, -1, 1100, dc);
    check("t3_pass_flip", pass, 0);

    // reset in the middle of FLUSH
    resp_mode = 1;
    seed = 16'h0001; n_vectors = CNT_W'(3); golden_sig = '0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    #2;
    I1477 = 1'b1;
    #1;
    check("t6_stim", stim_o, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_pass", pass, 0);
    check("t6_sig", signature, 0);
    check("t6_dut_rst", dut_rst_o, 1);
    step();
    I1477 = 1'b0;
    step();
    run(16'h0001, 2, 16'h0003, -1, -1, 50, dc);
    check("t6_rerun_cycle", dc, 1 + RST_CYC + 2 + LAT);
    check("t6_rerun_sig", signature, 16'h0003);
    check("t6_rerun_pass", pass, 1);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
